// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, frame/parity error pulses.
// Optional even-parity bit checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_parity_err
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = 1 + $clog2(CYCLES_PER_BIT);
  localparam int BW             = $clog2(PAYLOAD_BITS + 1);
  localparam int SW             = $clog2(STOP_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(PAYLOAD_BITS - 1);
  localparam logic [SW-1:0] STOPS_LAST = SW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    FLUSH
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cycle_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [SW-1:0]           stop_cnt;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic                    stop_err;
  logic                    rxd_m, rxd_s;
  logic [1:0]              sync_fill;
  logic                    armed;
  logic                    frame_bad;

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  // armed stays low until the real line has been seen high, so a frame cut by reset is not resumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
      rxd_m     <= uart_rxd;
      rxd_s     <= rxd_m;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rxd_s);
    end
  end

  assign frame_bad    = stop_err | ~rxd_s;
  assign uart_rx_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic parity_err_q;
  assign uart_rx_parity_err = parity_err_q;
`else
  assign uart_rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      cycle_cnt         <= '0;
      bit_cnt           <= '0;
      stop_cnt          <= '0;
      shift_reg         <= '0;
      stop_err          <= 1'b0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad           <= 1'b0;
      parity_err_q      <= 1'b0;
`endif
    end else begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q      <= 1'b0;
`endif
      if (state != IDLE && !uart_rx_en) begin
        state     <= IDLE;
        cycle_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (armed && uart_rx_en && !rxd_s) begin
              state     <= START;
              cycle_cnt <= '0;
              bit_cnt   <= '0;
              stop_cnt  <= '0;
              stop_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              par_bad   <= 1'b0;
`endif
            end
          end
          START: begin
            if (cycle_cnt == HALF_LAST) begin
              cycle_cnt <= '0;
              state     <= rxd_s ? IDLE : DATA;
            end else begin
              cycle_cnt <= cycle_cnt + CW'(1);
            end
          end
          DATA: begin
            if (cycle_cnt == BIT_LAST) begin
              cycle_cnt <= '0;
              shift_reg <= {rxd_s, shift_reg[PAYLOAD_BITS-1:1]};
              bit_cnt   <= bit_cnt + BW'(1);
              if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cycle_cnt <= cycle_cnt + CW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cycle_cnt == BIT_LAST) begin
              cycle_cnt <= '0;
              par_bad   <= ^{shift_reg, rxd_s};
              state     <= STOP;
            end else begin
              cycle_cnt <= cycle_cnt + CW'(1);
            end
          end
`endif
          STOP: begin
            if (cycle_cnt == BIT_LAST) begin
              cycle_cnt <= '0;
              if (stop_cnt == STOPS_LAST) begin
`ifdef UART_RX_PARITY_EN
                if (par_bad)        parity_err_q      <= 1'b1;
                else if (frame_bad) uart_rx_frame_err <= 1'b1;
`else
                if (frame_bad)      uart_rx_frame_err <= 1'b1;
`endif
                else begin
                  uart_rx_valid <= 1'b1;
                  uart_rx_data  <= shift_reg;
                end
                // A bad stop bit may be the start of a break; wait for the line to recover.
                state <= frame_bad ? FLUSH : IDLE;
              end else begin
                stop_cnt <= stop_cnt + SW'(1);
                stop_err <= frame_bad;
              end
            end else begin
              cycle_cnt <= cycle_cnt + CW'(1);
            end
          end
          FLUSH: begin
            if (rxd_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
